// File: rtl/ascon_pkg.sv
// Shared ASCON widths, FSM encoding and column helpers
// for the iterative substitution layer.
package ascon_pkg;

   localparam int ASCON_STATE_W = 320;
   localparam int ASCON_WORD_W  = 64;
   localparam int ASCON_SBOX_W  = 5;
   localparam int ASCON_NWORDS  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_fsm_e;

   typedef logic [ASCON_SBOX_W-1:0]  sbox_t;
   typedef logic [ASCON_STATE_W-1:0] state_t;

   // Bit b of a column lives in word (4-b); x0 lands in bit 4.
   function automatic sbox_t get_col(
      input state_t s,
      input int     j
   );
      sbox_t c;
      for (int b = 0; b < ASCON_NWORDS; b++) begin
         c[b] = s[b*ASCON_WORD_W + j];
      end
      return c;
   endfunction

   // Write a substituted column back into the same bit slice.
   function automatic state_t put_col(
      input state_t s,
      input int     j,
      input sbox_t  y
   );
      state_t r;
      r = s;
      for (int b = 0; b < ASCON_NWORDS; b++) begin
         r[b*ASCON_WORD_W + j] = y[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/ascon_sub_layer_if.sv
// Valid/ready bundle between constant addition, the
// substitution layer and the linear diffusion layer.
interface ascon_sub_layer_if;
   import ascon_pkg::*;

   logic   in_valid;
   logic   in_ready;
   state_t in_state;
   logic   out_valid;
   logic   out_ready;
   state_t out_state;

   modport master (
      output in_valid,
      output in_state,
      input  in_ready,
      input  out_valid,
      input  out_state,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_state,
      output in_ready,
      output out_valid,
      output out_state,
      input  out_ready
   );

endinterface

// File: rtl/s_box.sv
// ASCON 5-bit S-box as a pure lookup table.
// Input bit 4 is x0, output bit 4 returns to x0.
module s_box
   import ascon_pkg::*;
(
   input  sbox_t x_i,
   output sbox_t y_o
);

   // 32-entry substitution table
   always_comb begin
      y_o = '0;
      case (x_i)
         5'h00: y_o = 5'h04;
         5'h01: y_o = 5'h0b;
         5'h02: y_o = 5'h1f;
         5'h03: y_o = 5'h14;
         5'h04: y_o = 5'h1a;
         5'h05: y_o = 5'h15;
         5'h06: y_o = 5'h09;
         5'h07: y_o = 5'h02;
         5'h08: y_o = 5'h1b;
         5'h09: y_o = 5'h05;
         5'h0a: y_o = 5'h08;
         5'h0b: y_o = 5'h12;
         5'h0c: y_o = 5'h1d;
         5'h0d: y_o = 5'h03;
         5'h0e: y_o = 5'h06;
         5'h0f: y_o = 5'h1c;
         5'h10: y_o = 5'h1e;
         5'h11: y_o = 5'h13;
         5'h12: y_o = 5'h07;
         5'h13: y_o = 5'h0e;
         5'h14: y_o = 5'h00;
         5'h15: y_o = 5'h0d;
         5'h16: y_o = 5'h11;
         5'h17: y_o = 5'h18;
         5'h18: y_o = 5'h10;
         5'h19: y_o = 5'h0c;
         5'h1a: y_o = 5'h01;
         5'h1b: y_o = 5'h19;
         5'h1c: y_o = 5'h16;
         5'h1d: y_o = 5'h0a;
         5'h1e: y_o = 5'h0f;
         5'h1f: y_o = 5'h17;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/ascon_sub_layer.sv
// Iterative ASCON substitution layer, LANES columns/cycle.
// Optional abort port under ASCON_SUB_ABORT_EN.
module ascon_sub_layer
   import ascon_pkg::*;
#(
   parameter int LANES = 8
)
(
   input  logic clk,
   input  logic rst,
`ifdef ASCON_SUB_ABORT_EN
   input  logic abort,
`endif
   ascon_sub_layer_if.slave bus,
   output logic busy
);

   localparam int N  = ASCON_WORD_W / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (LANES < 1 || LANES > ASCON_WORD_W ||
       (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
      $error("LANES must be a power of two in 1..64");
   end

   sub_fsm_e      st_q;
   logic [CW-1:0] cnt_q;
   state_t        state_q;
   state_t        state_d;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          busy_q;
   logic          last;
   logic          kill;

   sbox_t sb_in  [LANES];
   sbox_t sb_out [LANES];

   // Width-1 counter stays at zero when a single group covers
   // all columns, so the first RUN cycle is also the last.
   assign last = (cnt_q == CW'(N - 1));

`ifdef ASCON_SUB_ABORT_EN
   assign kill = abort && (st_q != IDLE);
`else
   assign kill = 1'b0;
`endif

   // Gather the active column group into the lane inputs
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sb_in[l] = '0;
         for (int g = 0; g < N; g++) begin
            if (cnt_q == CW'(g)) begin
               sb_in[l] = get_col(state_q, g*LANES + l);
            end
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      s_box u_sbox (
         .x_i (sb_in[l]),
         .y_o (sb_out[l])
      );
   end

   // Scatter lane results back; other columns pass through
   always_comb begin
      state_d = state_q;
      for (int j = 0; j < ASCON_WORD_W; j++) begin
         if (cnt_q == CW'(j / LANES)) begin
            state_d = put_col(state_d, j, sb_out[j % LANES]);
         end
      end
   end

   // Control FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         st_q        <= IDLE;
         cnt_q       <= '0;
         state_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (st_q)
            IDLE: begin
               if (bus.in_valid) begin
                  state_q    <= bus.in_state;
                  cnt_q      <= '0;
                  st_q       <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               state_q <= state_d;
               if (last) begin
                  cnt_q       <= '0;
                  st_q        <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  st_q        <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               st_q        <= IDLE;
               cnt_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = state_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_ascon_sub_layer.sv
// Bench for ascon_sub_layer at LANES=8, 1 and 64 against
// a column-by-column S-box reference model.
module tb_ascon_sub_layer;
   import ascon_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]   iv    = '0;
   logic [2:0]   ordy  = '0;
   logic [319:0] st_in = '0;
   logic [2:0]   ir;
   logic [2:0]   ov;
   logic [2:0]   bz;
   logic [319:0] os [3];
`ifdef ASCON_SUB_ABORT_EN
   logic abort = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int lat [3] = '{8, 64, 1};
   int sbt [32] = '{4, 11, 31, 20, 26, 21, 9, 2,
                    27, 5, 8, 18, 29, 3, 6, 28,
                    30, 19, 7, 14, 0, 13, 17, 24,
                    16, 12, 1, 25, 22, 10, 15, 23};

   ascon_sub_layer_if b0 ();
   ascon_sub_layer_if b1 ();
   ascon_sub_layer_if b2 ();

   assign b0.in_valid  = iv[0];
   assign b0.in_state  = st_in;
   assign b0.out_ready = ordy[0];
   assign b1.in_valid  = iv[1];
   assign b1.in_state  = st_in;
   assign b1.out_ready = ordy[1];
   assign b2.in_valid  = iv[2];
   assign b2.in_state  = st_in;
   assign b2.out_ready = ordy[2];

   assign ir = {b2.in_ready, b1.in_ready, b0.in_ready};
   assign ov = {b2.out_valid, b1.out_valid, b0.out_valid};
   assign os[0] = b0.out_state;
   assign os[1] = b1.out_state;
   assign os[2] = b2.out_state;

   ascon_sub_layer #(.LANES(8)) u_l8 (
      .clk   (clk),
      .rst   (rst),
`ifdef ASCON_SUB_ABORT_EN
      .abort (abort),
`endif
      .bus   (b0.slave),
      .busy  (bz[0])
   );

   ascon_sub_layer #(.LANES(1)) u_l1 (
      .clk   (clk),
      .rst   (rst),
`ifdef ASCON_SUB_ABORT_EN
      .abort (abort),
`endif
      .bus   (b1.slave),
      .busy  (bz[1])
   );

   ascon_sub_layer #(.LANES(64)) u_l64 (
      .clk   (clk),
      .rst   (rst),
`ifdef ASCON_SUB_ABORT_EN
      .abort (abort),
`endif
      .bus   (b2.slave),
      .busy  (bz[2])
   );

   task automatic check(
      input string        tag,
      input logic [319:0] got,
      input logic [319:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every column through the table, x0 as the MSB.
   function automatic logic [319:0] ref_sub(input logic [319:0] s);
      logic [319:0] r;
      int x;
      int y;
      r = s;
      for (int j = 0; j < 64; j++) begin
         x = 0;
         for (int w = 0; w < 5; w++) x = x*2 + int'(s[(4-w)*64 + j]);
         y = sbt[x];
         for (int w = 0; w < 5; w++) r[(4-w)*64 + j] = y[4-w];
      end
      return r;
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Wait for out_valid; result is edges after the accept edge.
   task automatic wait_ov(input int k, output int c);
      c = 0;
      while (!ov[k] && c < 200) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic xfer(
      input int           k,
      input logic [319:0] s,
      input logic [319:0] exp
   );
      int c;
      @(negedge clk);
      check("in_ready_idle", ir[k], 1'b1);
      st_in = s;
      iv[k] = 1'b1;
      @(negedge clk);
      iv[k] = 1'b0;
      check("busy_run", bz[k], 1'b1);
      wait_ov(k, c);
      check("latency", c, lat[k]);
      check("result", os[k], exp);
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      check("ov_after_hs", ov[k], 1'b0);
      check("ir_after_hs", ir[k], 1'b1);
   endtask

   logic [319:0] s1, s2, snap;
   logic [319:0] e_zero, e_ones, e_one;
   int c;

   initial begin
      e_zero = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
      e_ones = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF};
      e_one  = {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_in_ready", ir[k], 1'b1);
         check("rst_out_valid", ov[k], 1'b0);
         check("rst_busy", bz[k], 1'b0);
         check("rst_out_state", os[k], '0);
      end

      xfer(0, '0, e_zero);
      xfer(0, {320{1'b1}}, e_ones);
      xfer(0, 320'h1, e_one);
      xfer(1, 320'h1, e_one);
      xfer(2, 320'h1, e_one);

      for (int i = 0; i < 10; i++) begin
         s1 = rnd320();
         xfer(0, s1, ref_sub(s1));
      end
      for (int i = 0; i < 3; i++) begin
         s1 = rnd320();
         xfer(1, s1, ref_sub(s1));
         s1 = rnd320();
         xfer(2, s1, ref_sub(s1));
      end

      // Backpressure in DONE with a second state waiting
      s1 = rnd320();
      s2 = rnd320();
      @(negedge clk);
      st_in = s1;
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      wait_ov(0, c);
      check("bp_latency", c, 8);
      snap = os[0];
      check("bp_result", snap, ref_sub(s1));
      st_in = s2;
      iv[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", os[0], snap);
         check("bp_in_ready", ir[0], 1'b0);
         check("bp_out_valid", ov[0], 1'b1);
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      check("bp_ov_drop", ov[0], 1'b0);
      check("bp_ir_rise", ir[0], 1'b1);
      @(negedge clk);
      iv[0] = 1'b0;
      check("bp_second_accept", bz[0], 1'b1);
      wait_ov(0, c);
      check("bp2_latency", c, 8);
      check("bp2_result", os[0], ref_sub(s2));
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;

      // Reset mid-RUN
      @(negedge clk);
      st_in = rnd320();
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rrun_out_valid", ov[0], 1'b0);
      check("rrun_busy", bz[0], 1'b0);
      check("rrun_in_ready", ir[0], 1'b1);
      check("rrun_out_state", os[0], '0);
      repeat (10) @(negedge clk);
      check("rrun_no_ov", ov[0], 1'b0);
      xfer(0, '0, e_zero);

      // Reset while holding a result in DONE
      @(negedge clk);
      st_in = rnd320();
      iv[2] = 1'b1;
      @(negedge clk);
      iv[2] = 1'b0;
      wait_ov(2, c);
      check("rdone_ov_high", ov[2], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rdone_ov_drop", ov[2], 1'b0);
      check("rdone_out_state", os[2], '0);

`ifdef ASCON_SUB_ABORT_EN
      // Abort during RUN
      @(negedge clk);
      st_in = rnd320();
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_run_ov", ov[0], 1'b0);
      check("ab_run_busy", bz[0], 1'b0);
      check("ab_run_ir", ir[0], 1'b1);
      check("ab_run_state", os[0], '0);
      repeat (10) @(negedge clk);
      check("ab_run_no_ov", ov[0], 1'b0);

      // Abort in DONE
      s1 = rnd320();
      @(negedge clk);
      st_in = s1;
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      wait_ov(0, c);
      check("ab_done_result", os[0], ref_sub(s1));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_done_ov", ov[0], 1'b0);
      check("ab_done_state", os[0], '0);

      // Abort in IDLE does not block a load
      s1 = rnd320();
      @(negedge clk);
      st_in = s1;
      iv[0] = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      abort = 1'b0;
      check("ab_idle_load", bz[0], 1'b1);
      wait_ov(0, c);
      check("ab_idle_result", os[0], ref_sub(s1));
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ascon_sub_layer.md
# ascon_sub_layer

Iterative ASCON substitution layer: accepts the 320-bit permutation state after constant addition, applies the 5-bit ASCON S-box to all 64 bit-slice columns, and hands the result to the linear diffusion layer. Columns are processed LANES at a time through parallel `s_box` instances, so area and latency trade off via one parameter. Valid/ready handshakes on both sides.

## Interface
- LANES, default 8: S-box instances, i.e. columns per cycle; must be a power of two in 1..64, else elaboration error.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a state.
- in_ready  output  1  block can accept; high only in IDLE.
- in_state  input  320  [319:256]=x0, [255:192]=x1, [191:128]=x2, [127:64]=x3, [63:0]=x4.
- out_valid  output  1  substituted state available; high only in DONE.
- out_ready  input  1  downstream accepts.
- out_state  output  320  same word layout as in_state; driven from internal state register.
- busy  output  1  high in RUN or DONE.

## Operation
- Column j (0..63): S-box input x = {x0[j], x1[j], x2[j], x3[j], x4[j]} (x0 is bit 4); output y[4..0] written back to x0[j]..x4[j].
- FSM states IDLE, RUN, DONE; column counter cnt, width log2(64/LANES) (zero width when LANES=64: RUN lasts one cycle).
- IDLE: in_ready=1. in_valid=1 loads in_state into state register, cnt=0, go RUN. Otherwise hold.
- RUN: columns cnt*LANES .. cnt*LANES+LANES-1 replaced in place; other columns unchanged; cnt increments. On last group (cnt = 64/LANES-1) cnt wraps to 0 and go DONE.
- DONE: out_valid=1, out_state stable. out_ready=1 -> IDLE. out_ready=0 -> hold indefinitely; no new input accepted.
- in_valid ignored outside IDLE; out_ready ignored outside DONE.
- Reset values: FSM IDLE, cnt 0, state register 0, out_valid 0, busy 0, out_state 0; in_ready 1 from first cycle after reset deasserts.
- rst high at any point (including mid-RUN or DONE with out_valid high) aborts the current state at that edge; no partial result emitted.

## Timing
- N = 64/LANES. Accept edge E0; RUN occupies N cycles; out_valid rises after edge E0+N.
- Output handshake edge returns to IDLE; in_ready high next cycle. Minimum interval between accepts N+2 cycles.
- in_ready and out_valid are decoded from FSM register only (no combinational path from in_valid/out_ready).
- S-box path is combinational within one cycle: state register -> mux by cnt -> s_box -> state register.

## Configuration
- ASCON_SUB_ABORT_EN defined: extra input port abort (1 bit). abort=1 in RUN or DONE -> next edge IDLE, state register cleared to 0, cnt 0, out_valid 0. abort in IDLE has no effect; rst has priority over abort; abort and in_valid in IDLE -> load proceeds.
- Undefined: port absent; only rst interrupts an operation.

## Structure
- Shared package ascon_pkg: ASCON_STATE_W=320, ASCON_WORD_W=64, ASCON_SBOX_W=5, FSM state enum (IDLE/RUN/DONE).
- Sub-module: existing `s_box` LUT, instantiated LANES times in a generate loop; column gather/scatter and counter in this block.

## Test plan
- All-zero state, LANES=8 -> out x0=0, x1=0, x2=FFFF_FFFF_FFFF_FFFF, x3=0, x4=0; out_valid rises 8 cycles after accept.
- All-ones state -> x0, x2, x3, x4 = all ones, x1=0 (S(31)=23).
- Only x4 bit 0 set -> x0=0, x1=1, x2=FFFF_FFFF_FFFF_FFFF, x3=1, x4=1 (column 0 S(1)=11, others S(0)=4); repeat for LANES=1 (64 cycles) and LANES=64 (1 cycle).
- out_ready held low 10 cycles in DONE with in_valid high -> out_state stable, in_ready 0, second state accepted only cycle after output handshake.
- rst pulsed mid-RUN -> next cycle out_valid 0, busy 0, in_ready 1, out_state 0; subsequent zero-state run gives correct result.
- ASCON_SUB_ABORT_EN: abort in cycle 3 of RUN -> IDLE next edge, no out_valid; abort in DONE -> out_valid drops next edge.
